// File: rtl/apb_defs_pkg.sv
// ---------------------------------------------------------------------------
// apb_defs
// Shared definitions for the APB slave: FSM state encoding, register file
// geometry, the read-only ID register and the address-field layout, plus the
// helper that classifies an access as erroneous.
// ---------------------------------------------------------------------------
package apb_defs;

  // Bus widths
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  // Address layout: [1:0] byte offset, [4:2] register index, [31:5] must be 0
  localparam int BYTE_W  = 2;
  localparam int IDX_W   = 3;
  localparam int IDX_LSB = BYTE_W;
  localparam int IDX_MSB = BYTE_W + IDX_W - 1;

  // Register file geometry and the fixed identification register
  localparam int                REG_COUNT = 8;
  localparam logic [IDX_W-1:0]  ID_INDEX  = 3'd7;
  localparam logic [DATA_W-1:0] ID_VALUE  = 32'h0000_0019;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_WAIT   = 2'd2,
    ST_ACCESS = 2'd3
  } apb_state_t;

  // An access errors on a misaligned address, on any address outside the
  // 32-byte register window, or on a write to the read-only ID register.
  function automatic logic addr_error(input logic [ADDR_W-1:0] addr,
                                      input logic              write);
    return (addr[BYTE_W-1:0] != '0) ||
           (addr[ADDR_W-1:IDX_MSB+1] != '0) ||
           (write && (addr[IDX_MSB:IDX_LSB] == ID_INDEX));
  endfunction

endpackage

// File: rtl/apb_slave_regfile.sv
// ---------------------------------------------------------------------------
// apb_slave_regfile
// 8 x 32-bit register array. Entries 0..6 are read/write; entry 7 always
// reads back the fixed ID value and ignores writes.
// Ports:
//   clk    - clock, rising edge
//   rst_n  - synchronous active-low reset, clears the writable entries
//   we     - write enable for this cycle
//   waddr  - write index
//   wdata  - write data
//   raddr  - read index (combinational read)
//   rdata  - read data
// ---------------------------------------------------------------------------
module apb_slave_regfile
  import apb_defs::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [IDX_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [IDX_W-1:0]  raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] regs [REG_COUNT];

  // Storage behind the ID index is never written, so it simply stays at 0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < REG_COUNT; i++) begin
        regs[i] <= '0;
      end
    end else if (we && (waddr != ID_INDEX)) begin
      regs[waddr] <= wdata;
    end
  end

  always_comb begin
    rdata = regs[raddr];
    if (raddr == ID_INDEX) begin
      rdata = ID_VALUE;
    end
  end

endmodule

// File: rtl/apb_slave_interface.sv
// ---------------------------------------------------------------------------
// apb_slave_interface
// APB slave in front of an 8-entry register file, with a configurable number
// of wait states, error response and abort handling.
// Parameters:
//   SEL_INDEX   - which bit of Pselx selects this slave (0..2)
//   WAIT_STATES - extra access cycles before Pready (0..3)
// Ports:
//   Hclk    - clock, rising edge
//   Hresetn - synchronous active-low reset
//   Pselx   - one-hot peripheral select
//   Penable - access phase indicator
//   Pwrite  - 1 = write, 0 = read
//   Paddr   - byte address
//   Pwdata  - write data
//   Prdata  - registered read data, non-zero only in the Pready cycle
//   Pready  - registered transfer completion, one cycle wide
//   Pslverr - registered error flag, valid with Pready
// ---------------------------------------------------------------------------
module apb_slave_interface
  import apb_defs::*;
#(
  parameter int SEL_INDEX   = 0,
  parameter int WAIT_STATES = 1
) (
  input  logic              Hclk,
  input  logic              Hresetn,
  input  logic [2:0]        Pselx,
  input  logic              Penable,
  input  logic              Pwrite,
  input  logic [ADDR_W-1:0] Paddr,
  input  logic [DATA_W-1:0] Pwdata,
  output logic [DATA_W-1:0] Prdata,
  output logic              Pready,
  output logic              Pslverr
);

  apb_state_t        state;
  apb_state_t        state_next;
  apb_state_t        cur;
  logic [1:0]        cnt;
  logic [1:0]        cnt_next;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              write_q;
  logic              sel;
  logic [ADDR_W-1:0] acc_addr;
  logic              acc_write;
  logic              acc_err;
  logic              commit;
  logic [DATA_W-1:0] rd_data;

  // Masking keeps every select bit in the expression; only SEL_INDEX matters.
  assign sel = |(Pselx & (3'b001 << SEL_INDEX));

  // The setup cycle is seen while the register still says IDLE, so SETUP is
  // the decoded state of that cycle. Resolving it here lets Pready appear in
  // the first enable cycle when there are no wait states.
  always_comb begin
    cur        = state;
    state_next = ST_IDLE;
    cnt_next   = '0;
    if ((state == ST_IDLE) && sel && !Penable) begin
      cur = ST_SETUP;
    end
    case (cur)
      ST_IDLE: begin
        state_next = ST_IDLE;
      end
      ST_SETUP: begin
        if (WAIT_STATES > 0) begin
          state_next = ST_WAIT;
          cnt_next   = 2'(WAIT_STATES - 1);
        end else begin
          state_next = ST_ACCESS;
        end
      end
      ST_WAIT: begin
        if (!(sel && Penable)) begin
          state_next = ST_IDLE;
        end else if (cnt == 2'd0) begin
          state_next = ST_ACCESS;
        end else begin
          state_next = ST_WAIT;
          cnt_next   = cnt - 2'd1;
        end
      end
      ST_ACCESS: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // During the setup cycle the latches are not loaded yet, so look at the bus.
  assign acc_addr  = (cur == ST_SETUP) ? Paddr  : addr_q;
  assign acc_write = (cur == ST_SETUP) ? Pwrite : write_q;
  assign acc_err   = addr_error(acc_addr, acc_write);

  // Write lands on the edge closing the Pready cycle, unless aborted there.
  assign commit = (state == ST_ACCESS) && sel && Penable && write_q && !acc_err;

  always_ff @(posedge Hclk) begin
    if (!Hresetn) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      write_q <= 1'b0;
      Pready  <= 1'b0;
      Pslverr <= 1'b0;
      Prdata  <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      if (cur == ST_SETUP) begin
        addr_q  <= Paddr;
        write_q <= Pwrite;
        wdata_q <= Pwdata;
      end
      Pready  <= (state_next == ST_ACCESS);
      Pslverr <= (state_next == ST_ACCESS) && acc_err;
      Prdata  <= ((state_next == ST_ACCESS) && !acc_err && !acc_write) ? rd_data : '0;
    end
  end

  apb_slave_regfile u_regfile (
    .clk   (Hclk),
    .rst_n (Hresetn),
    .we    (commit),
    .waddr (addr_q[IDX_MSB:IDX_LSB]),
    .wdata (wdata_q),
    .raddr (acc_addr[IDX_MSB:IDX_LSB]),
    .rdata (rd_data)
  );

endmodule

// File: tb/tb_apb_slave_interface.sv
// ---------------------------------------------------------------------------
// tb_apb_slave_interface
// Directed bench for apb_slave_interface. Three instances share the bus
// signals but have private selects:
//   dut 0: SEL_INDEX=0, WAIT_STATES=1
//   dut 1: SEL_INDEX=2, WAIT_STATES=0
//   dut 2: SEL_INDEX=0, WAIT_STATES=3
// Inputs change on the falling edge; outputs are sampled there too.
// ---------------------------------------------------------------------------
module tb_apb_slave_interface;

  localparam int MAX_LAT = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  psel [3];
  logic        penable;
  logic        pwrite;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata [3];
  logic        pready [3];
  logic        pslverr [3];

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  apb_slave_interface #(.SEL_INDEX(0), .WAIT_STATES(1)) u_dut0 (
    .Hclk(clk), .Hresetn(rst_n), .Pselx(psel[0]), .Penable(penable),
    .Pwrite(pwrite), .Paddr(paddr), .Pwdata(pwdata),
    .Prdata(prdata[0]), .Pready(pready[0]), .Pslverr(pslverr[0]));

  apb_slave_interface #(.SEL_INDEX(2), .WAIT_STATES(0)) u_dut1 (
    .Hclk(clk), .Hresetn(rst_n), .Pselx(psel[1]), .Penable(penable),
    .Pwrite(pwrite), .Paddr(paddr), .Pwdata(pwdata),
    .Prdata(prdata[1]), .Pready(pready[1]), .Pslverr(pslverr[1]));

  apb_slave_interface #(.SEL_INDEX(0), .WAIT_STATES(3)) u_dut2 (
    .Hclk(clk), .Hresetn(rst_n), .Pselx(psel[2]), .Penable(penable),
    .Pwrite(pwrite), .Paddr(paddr), .Pwdata(pwdata),
    .Prdata(prdata[2]), .Pready(pready[2]), .Pslverr(pslverr[2]));

  // Select pattern that addresses instance d
  function automatic logic [2:0] sel_code(input int d);
    return (d == 1) ? 3'b100 : 3'b001;
  endfunction

  task automatic select_only(input int d, input logic [2:0] code);
    for (int i = 0; i < 3; i++) psel[i] = (i == d) ? code : 3'b000;
  endtask

  task automatic bus_idle(input int n);
    for (int i = 0; i < 3; i++) psel[i] = 3'b000;
    penable = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  // Full transfer starting at a falling edge: setup now, enable next cycle,
  // wait (bounded) for Pready, then step one more cycle and report the
  // outputs seen in that following cycle. Returns at a falling edge.
  task automatic apb_xfer(input int d, input logic wr, input logic [31:0] addr,
                          input logic [31:0] data, output logic [31:0] rd,
                          output logic err, output int lat,
                          output logic ready_after, output logic [31:0] rdata_after);
    select_only(d, sel_code(d));
    penable = 1'b0;
    pwrite  = wr;
    paddr   = addr;
    pwdata  = data;
    @(negedge clk);
    penable = 1'b1;
    lat     = 1;
    while (pready[d] !== 1'b1 && lat < MAX_LAT) begin
      @(negedge clk);
      lat++;
    end
    vectors++;
    if (pready[d] !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL xfer_timeout dut%0d addr %h: pready %b after %0d cycles, required 1",
               d, addr, pready[d], lat);
    end
    rd  = prdata[d];
    err = pslverr[d];
    @(negedge clk);
    ready_after = pready[d];
    rdata_after = prdata[d];
  endtask

  task automatic test_reset();
    for (int d = 0; d < 3; d++) begin
      vectors++;
      if (pready[d] !== 1'b0) begin
        miscompares++; $display("[TB] FAIL reset_pready dut%0d: got %b required 0", d, pready[d]);
      end
      vectors++;
      if (pslverr[d] !== 1'b0) begin
        miscompares++; $display("[TB] FAIL reset_pslverr dut%0d: got %b required 0", d, pslverr[d]);
      end
      vectors++;
      if (prdata[d] !== 32'h0) begin
        miscompares++; $display("[TB] FAIL reset_prdata dut%0d: got %h required 0", d, prdata[d]);
      end
    end
    rst_n = 1'b1;
  endtask

  // Zero wait states: first transfer right out of reset, read of the ID.
  task automatic test_first_transfer();
    logic [31:0] rd, ra; logic err, rdy; int lat;
    apb_xfer(1, 1'b0, 32'h1C, 32'h0, rd, err, lat, rdy, ra);
    vectors++;
    if (rd !== 32'h19) begin miscompares++; $display("[TB] FAIL id_read_data: got %h required %h", rd, 32'h19); end
    vectors++;
    if (err !== 1'b0) begin miscompares++; $display("[TB] FAIL id_read_err: got %b required 0", err); end
    vectors++;
    if (lat !== 1) begin miscompares++; $display("[TB] FAIL ws0_latency: got %0d required 1", lat); end
    vectors++;
    if (rdy !== 1'b0) begin miscompares++; $display("[TB] FAIL pready_one_cycle: got %b required 0", rdy); end
    vectors++;
    if (ra !== 32'h0) begin miscompares++; $display("[TB] FAIL prdata_after_ready: got %h required 0", ra); end
  endtask

  task automatic test_id_protect();
    logic [31:0] rd, ra; logic err, rdy; int lat;
    apb_xfer(1, 1'b1, 32'h1C, 32'h1, rd, err, lat, rdy, ra);
    vectors++;
    if (err !== 1'b1) begin miscompares++; $display("[TB] FAIL id_write_err: got %b required 1", err); end
    vectors++;
    if (rd !== 32'h0) begin miscompares++; $display("[TB] FAIL id_write_prdata: got %h required 0", rd); end
    apb_xfer(1, 1'b0, 32'h1C, 32'h0, rd, err, lat, rdy, ra);
    vectors++;
    if (rd !== 32'h19) begin miscompares++; $display("[TB] FAIL id_reread_data: got %h required %h", rd, 32'h19); end
    vectors++;
    if (err !== 1'b0) begin miscompares++; $display("[TB] FAIL id_reread_err: got %b required 0", err); end
  endtask

  // One wait state: write then back-to-back read of the same register.
  task automatic test_write_read();
    logic [31:0] rd, ra; logic err, rdy; int lat;
    apb_xfer(0, 1'b1, 32'h8, 32'hDEAD_BEEF, rd, err, lat, rdy, ra);
    vectors++;
    if (err !== 1'b0) begin miscompares++; $display("[TB] FAIL wr8_err: got %b required 0", err); end
    vectors++;
    if (lat !== 2) begin miscompares++; $display("[TB] FAIL ws1_wr_latency: got %0d required 2", lat); end
    apb_xfer(0, 1'b0, 32'h8, 32'h0, rd, err, lat, rdy, ra);
    vectors++;
    if (rd !== 32'hDEAD_BEEF) begin miscompares++; $display("[TB] FAIL rd8_data: got %h required %h", rd, 32'hDEAD_BEEF); end
    vectors++;
    if (err !== 1'b0) begin miscompares++; $display("[TB] FAIL rd8_err: got %b required 0", err); end
    vectors++;
    if (lat !== 2) begin miscompares++; $display("[TB] FAIL ws1_rd_latency: got %0d required 2", lat); end
  endtask

  task automatic test_bad_address();
    logic [31:0] rd, ra; logic err, rdy; int lat;
    apb_xfer(0, 1'b1, 32'h40, 32'h1234_5678, rd, err, lat, rdy, ra);
    vectors++;
    if (err !== 1'b1) begin miscompares++; $display("[TB] FAIL wr40_err: got %b required 1", err); end
    apb_xfer(0, 1'b0, 32'h22, 32'h0, rd, err, lat, rdy, ra);
    vectors++;
    if (err !== 1'b1) begin miscompares++; $display("[TB] FAIL rd22_err: got %b required 1", err); end
    vectors++;
    if (rd !== 32'h0) begin miscompares++; $display("[TB] FAIL rd22_prdata: got %h required 0", rd); end
    apb_xfer(0, 1'b0, 32'h0, 32'h0, rd, err, lat, rdy, ra);
    vectors++;
    if (rd !== 32'h0) begin miscompares++; $display("[TB] FAIL wr40_alias: got %h required 0", rd); end
    apb_xfer(0, 1'b0, 32'h8, 32'h0, rd, err, lat, rdy, ra);
    vectors++;
    if (rd !== 32'hDEAD_BEEF) begin miscompares++; $display("[TB] FAIL rd22_side_effect: got %h required %h", rd, 32'hDEAD_BEEF); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd, ra; logic err, rdy; int lat;
    apb_xfer(0, 1'b1, 32'h0,  32'hA5A5_0001, rd, err, lat, rdy, ra);
    apb_xfer(0, 1'b1, 32'h18, 32'h0000_C0DE, rd, err, lat, rdy, ra);
    apb_xfer(0, 1'b0, 32'h0,  32'h0, rd, err, lat, rdy, ra);
    vectors++;
    if (rd !== 32'hA5A5_0001) begin miscompares++; $display("[TB] FAIL b2b_rd0: got %h required %h", rd, 32'hA5A5_0001); end
    vectors++;
    if (lat !== 2) begin miscompares++; $display("[TB] FAIL b2b_latency: got %0d required 2", lat); end
    apb_xfer(0, 1'b0, 32'h18, 32'h0, rd, err, lat, rdy, ra);
    vectors++;
    if (rd !== 32'h0000_C0DE) begin miscompares++; $display("[TB] FAIL b2b_rd6: got %h required %h", rd, 32'h0000_C0DE); end
    apb_xfer(1, 1'b1, 32'h4, 32'h1234_5678, rd, err, lat, rdy, ra);
    apb_xfer(1, 1'b0, 32'h4, 32'h0, rd, err, lat, rdy, ra);
    vectors++;
    if (rd !== 32'h1234_5678) begin miscompares++; $display("[TB] FAIL ws0_raw: got %h required %h", rd, 32'h1234_5678); end
    vectors++;
    if (lat !== 1) begin miscompares++; $display("[TB] FAIL ws0_b2b_latency: got %0d required 1", lat); end
  endtask

  // Select a different slave bit: dut 0 must never respond or write.
  task automatic test_wrong_select();
    logic [31:0] rd, ra; logic err, rdy; int lat; logic seen;
    select_only(0, 3'b010);
    penable = 1'b0; pwrite = 1'b1; paddr = 32'hC; pwdata = 32'h0000_FFFF;
    seen = 1'b0;
    @(negedge clk);
    penable = 1'b1;
    seen = seen | pready[0];
    repeat (4) begin @(negedge clk); seen = seen | pready[0]; end
    vectors++;
    if (seen !== 1'b0) begin miscompares++; $display("[TB] FAIL wrong_sel_pready: got %b required 0", seen); end
    bus_idle(1);
    apb_xfer(0, 1'b0, 32'hC, 32'h0, rd, err, lat, rdy, ra);
    vectors++;
    if (rd !== 32'h0) begin miscompares++; $display("[TB] FAIL wrong_sel_write: got %h required 0", rd); end
  endtask

  // Three wait states: normal transfer, then a write aborted in WAIT.
  task automatic test_abort();
    logic [31:0] rd, ra; logic err, rdy; int lat; logic seen;
    apb_xfer(2, 1'b1, 32'h14, 32'h0000_0099, rd, err, lat, rdy, ra);
    vectors++;
    if (lat !== 4) begin miscompares++; $display("[TB] FAIL ws3_latency: got %0d required 4", lat); end
    apb_xfer(2, 1'b0, 32'h14, 32'h0, rd, err, lat, rdy, ra);
    vectors++;
    if (rd !== 32'h0000_0099) begin miscompares++; $display("[TB] FAIL ws3_rd: got %h required %h", rd, 32'h99); end
    bus_idle(1);
    select_only(2, 3'b001);
    penable = 1'b0; pwrite = 1'b1; paddr = 32'h10; pwdata = 32'h0000_0077;
    seen = 1'b0;
    @(negedge clk); penable = 1'b1; seen = seen | pready[2];
    @(negedge clk); penable = 1'b0; seen = seen | pready[2];
    @(negedge clk); psel[2] = 3'b000; seen = seen | pready[2];
    repeat (4) begin @(negedge clk); seen = seen | pready[2]; end
    vectors++;
    if (seen !== 1'b0) begin miscompares++; $display("[TB] FAIL abort_pready: got %b required 0", seen); end
    apb_xfer(2, 1'b0, 32'h10, 32'h0, rd, err, lat, rdy, ra);
    vectors++;
    if (rd !== 32'h0) begin miscompares++; $display("[TB] FAIL abort_no_write: got %h required 0", rd); end
  endtask

  task automatic test_reset_mid_transfer();
    logic [31:0] rd, ra; logic err, rdy; int lat;
    bus_idle(1);
    select_only(2, 3'b001);
    penable = 1'b0; pwrite = 1'b1; paddr = 32'h4; pwdata = 32'h5;
    @(negedge clk); penable = 1'b1;
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk);
    vectors++;
    if ({pready[2], pslverr[2], prdata[2]} !== 34'h0) begin
      miscompares++;
      $display("[TB] FAIL mid_reset_outputs: got pready %b pslverr %b prdata %h required all 0",
               pready[2], pslverr[2], prdata[2]);
    end
    rst_n = 1'b1;
    bus_idle(1);
    apb_xfer(2, 1'b0, 32'h4, 32'h0, rd, err, lat, rdy, ra);
    vectors++;
    if (rd !== 32'h0) begin miscompares++; $display("[TB] FAIL mid_reset_no_write: got %h required 0", rd); end
    vectors++;
    if (err !== 1'b0) begin miscompares++; $display("[TB] FAIL mid_reset_rd_err: got %b required 0", err); end
    apb_xfer(0, 1'b0, 32'h8, 32'h0, rd, err, lat, rdy, ra);
    vectors++;
    if (rd !== 32'h0) begin miscompares++; $display("[TB] FAIL reset_clears_regs: got %h required 0", rd); end
  endtask

  initial begin
    rst_n   = 1'b0;
    penable = 1'b0;
    pwrite  = 1'b0;
    paddr   = '0;
    pwdata  = '0;
    for (int i = 0; i < 3; i++) psel[i] = 3'b000;
    repeat (3) @(negedge clk);
    test_reset();
    test_first_transfer();
    test_id_protect();
    test_write_read();
    test_bad_address();
    test_back_to_back();
    test_wrong_select();
    test_abort();
    test_reset_mid_transfer();
    bus_idle(2);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
